// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder for the MEM stage: one load/store at a time,
// fixed access latency, RV32I byte/half/word accesses with load extension.
module data_mem_resp #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    input  logic [2:0]       funct3,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] RD,
    output logic             fault
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    reqWe_q;
    logic [ADDR_WIDTH-1:0]   reqAddr_q;
    logic [WIDTH-1:0]        reqData_q;
    logic [2:0]              reqF3_q;
    logic                    reqFault_q;
    logic [WIDTH-1:0]        rd_q;
    logic                    ready_q;
    logic                    fault_q;
    logic [7:0]              mem_q [2**ADDR_WIDTH];

    logic                    faultNow;
    logic                    enterDone;
    logic                    accWe;
    logic [ADDR_WIDTH-1:0]   accAddr;
    logic [WIDTH-1:0]        accWd;
    logic [2:0]              accF3;
    logic                    accFault;
    logic [7:0]              rdByte [4];
    logic [3:0]              storeMask;
    logic [WIDTH-1:0]        loadValue;
    logic                    unusedAddr;

    function automatic logic isFault(input logic isStore, input logic [2:0] code,
                                     input logic [1:0] lowAddr);
        logic illegal;
        logic misaligned;
        if (isStore)
            illegal = (code > 3'd2);
        else
            illegal = (code == 3'b011) || (code == 3'b110) || (code == 3'b111);
        misaligned = ((code[1:0] == 2'b01) && lowAddr[0]) ||
                     ((code[1:0] == 2'b10) && (lowAddr != 2'b00));
        return illegal || misaligned;
    endfunction

    assign unusedAddr = ^A[WIDTH-1:ADDR_WIDTH];
    assign faultNow   = isFault(we, funct3, A[1:0]);

    // With LATENCY==1 the access completes straight out of IDLE, so the live
    // request inputs are used instead of the latched copy.
    always_comb begin
        accWe    = reqWe_q;
        accAddr  = reqAddr_q;
        accWd    = reqData_q;
        accF3    = reqF3_q;
        accFault = reqFault_q;
        if (state_q == IDLE) begin
            accWe    = we;
            accAddr  = A[ADDR_WIDTH-1:0];
            accWd    = WD;
            accF3    = funct3;
            accFault = faultNow;
        end
    end

    assign enterDone = ((state_q == IDLE) && req && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdByte[k] = mem_q[accAddr + ADDR_WIDTH'(k)];
        end
    end

    always_comb begin
        case (accF3[1:0])
            2'b00:   storeMask = 4'b0001;
            2'b01:   storeMask = 4'b0011;
            default: storeMask = 4'b1111;
        endcase
    end

    always_comb begin
        case (accF3)
            3'b000:  loadValue = {{(WIDTH-8){rdByte[0][7]}}, rdByte[0]};
            3'b001:  loadValue = {{(WIDTH-16){rdByte[1][7]}}, rdByte[1], rdByte[0]};
            3'b010:  loadValue = WIDTH'({rdByte[3], rdByte[2], rdByte[1], rdByte[0]});
            3'b100:  loadValue = WIDTH'(rdByte[0]);
            3'b101:  loadValue = WIDTH'({rdByte[1], rdByte[0]});
            default: loadValue = '0;
        endcase
    end

    // Storage is deliberately outside the reset domain; rst only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && enterDone && accWe && !accFault) begin
            for (int k = 0; k < 4; k++) begin
                if (storeMask[k])
                    mem_q[accAddr + ADDR_WIDTH'(k)] <= accWd[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            reqWe_q    <= 1'b0;
            reqAddr_q  <= '0;
            reqData_q  <= '0;
            reqF3_q    <= 3'd0;
            reqFault_q <= 1'b0;
            rd_q       <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        reqWe_q    <= we;
                        reqAddr_q  <= A[ADDR_WIDTH-1:0];
                        reqData_q  <= WD;
                        reqF3_q    <= funct3;
                        reqFault_q <= faultNow;
                        if (LATENCY > 1) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0)
                        state_q <= DONE;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (enterDone) begin
                ready_q <= 1'b1;
                fault_q <= accFault;
                rd_q    <= (accFault || accWe) ? '0 : loadValue;
            end
        end
    end

    assign busy  = !rst && (((state_q == IDLE) && req) || (state_q == WAIT));
    assign ready = ready_q;
    assign fault = fault_q;
    assign RD    = rd_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomized bench for data_mem_resp: four instances at latencies 2/1/3/15 checked
// against a byte-array reference model of the load/store rules.
module tb_data_mem_resp;

    localparam int NDUT = 4;

    function automatic int latOf(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
    endfunction

    logic        clk = 1'b0;
    logic        rst    [NDUT];
    logic        req    [NDUT];
    logic        we     [NDUT];
    logic [31:0] A      [NDUT];
    logic [31:0] WD     [NDUT];
    logic [2:0]  funct3 [NDUT];
    logic        busy   [NDUT];
    logic        ready  [NDUT];
    logic [31:0] RD     [NDUT];
    logic        fault  [NDUT];

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] refMem [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        data_mem_resp #(.WIDTH(32), .ADDR_WIDTH(17), .LATENCY(latOf(g))) uDut (
            .clk(clk), .rst(rst[g]), .req(req[g]), .we(we[g]), .A(A[g]), .WD(WD[g]),
            .funct3(funct3[g]), .busy(busy[g]), .ready(ready[g]), .RD(RD[g]),
            .fault(fault[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int refKey(input int i, input logic [31:0] a);
        return i * (1 << 17) + int'(a[16:0]);
    endfunction

    function automatic logic [7:0] readRef(input int i, input logic [31:0] a);
        int key = refKey(i, a);
        return refMem.exists(key) ? refMem[key] : 8'h00;
    endfunction

    // Reference: legality, alignment, little-endian bytes and sign extension by value.
    task automatic refAccess(input int i, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f,
                             output logic [31:0] rd, output logic flt);
        bit     legal;
        int     n;
        longint v;
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f[1:0];
        flt   = !legal || ((a % n) != 0);
        rd    = 32'h0;
        if (!flt) begin
            if (w) begin
                for (int k = 0; k < n; k++)
                    refMem[refKey(i, a + k)] = 8'(d >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < n; k++)
                    v += longint'(readRef(i, a + k)) << (8 * k);
                if (!f[2] && n < 4 && v >= (64'sd1 <<< (8 * n - 1)))
                    v -= (64'sd1 <<< (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic applyStimulus(input int i, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] f);
        int          lat = latOf(i);
        int          seen = 0;
        int          faultLeak = 0;
        logic [31:0] expRd;
        logic        expFault;
        refAccess(i, w, a, d, f, expRd, expFault);
        req[i] = 1'b1; we[i] = w; A[i] = a; WD[i] = d; funct3[i] = f;
        @(negedge clk);
        checkOutput($sformatf("d%0d.busyReq", i), 32'(busy[i]), 32'd1);
        for (int c = 1; c <= lat + 2 && seen == 0; c++) begin
            @(negedge clk);
            if (ready[i]) seen = c;
            else if (fault[i]) faultLeak++;
        end
        checkOutput($sformatf("d%0d.latency", i), seen, lat);
        checkOutput($sformatf("d%0d.faultIdle", i), faultLeak, 0);
        if (seen != 0) begin
            checkOutput($sformatf("d%0d.rd a=%08h f=%0d w=%0d", i, a, f, w), RD[i], expRd);
            checkOutput($sformatf("d%0d.fault", i), 32'(fault[i]), 32'(expFault));
            checkOutput($sformatf("d%0d.busyDone", i), 32'(busy[i]), 32'd0);
        end
        req[i] = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("d%0d.readyOnce", i), 32'(ready[i]), 32'd0);
        checkOutput($sformatf("d%0d.rdHold", i), RD[i], expRd);
        @(posedge clk); #1;
    endtask

    task automatic checkThroughput(input int i, input logic [31:0] a);
        int          lat = latOf(i);
        int          first = -1;
        int          second = -1;
        logic [31:0] expRd;
        logic        expFault;
        refAccess(i, 1'b0, a, 32'h0, 3'd2, expRd, expFault);
        req[i] = 1'b1; we[i] = 1'b0; A[i] = a; WD[i] = 32'h0; funct3[i] = 3'd2;
        for (int c = 0; c < 3 * (lat + 2) && second < 0; c++) begin
            @(negedge clk);
            if (ready[i]) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        req[i] = 1'b0;
        checkOutput($sformatf("d%0d.firstReady", i), first, lat);
        checkOutput($sformatf("d%0d.spacing", i), second - first, lat + 1);
        checkOutput($sformatf("d%0d.rdB2B", i), RD[i], expRd);
        @(posedge clk); #1;
    endtask

    task automatic countPulses(input int i, input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            pulses += int'(ready[i]);
        end
    endtask

    task automatic checkResetAbort(input int i);
        int lat = latOf(i);
        int pulses;
        applyStimulus(i, 1'b1, 32'h300, 32'hCAFEF00D, 3'd2);
        applyStimulus(i, 1'b0, 32'h300, 32'h0, 3'd2);
        // Store accepted, then reset lands while the access is still waiting.
        req[i] = 1'b1; we[i] = 1'b1; A[i] = 32'h300; WD[i] = 32'h12345678; funct3[i] = 3'd2;
        @(posedge clk); #1;
        rst[i] = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("d%0d.busyInRst", i), 32'(busy[i]), 32'd0);
        @(posedge clk); #1;
        rst[i] = 1'b0; req[i] = 1'b0;
        countPulses(i, lat + 2, pulses);
        checkOutput($sformatf("d%0d.abortPulses", i), pulses, 0);
        checkOutput($sformatf("d%0d.abortBusy", i), 32'(busy[i]), 32'd0);
        checkOutput($sformatf("d%0d.abortRd", i), RD[i], 32'h0);
        @(posedge clk); #1;
        // Reset coinciding with the accept cycle discards the request.
        req[i] = 1'b1; we[i] = 1'b1; A[i] = 32'h300; WD[i] = 32'h11111111; funct3[i] = 3'd2;
        rst[i] = 1'b1;
        @(posedge clk); #1;
        rst[i] = 1'b0; req[i] = 1'b0;
        countPulses(i, lat + 2, pulses);
        checkOutput($sformatf("d%0d.discardPulses", i), pulses, 0);
        @(posedge clk); #1;
        applyStimulus(i, 1'b0, 32'h300, 32'h0, 3'd2);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1; req[i] = 1'b1; we[i] = 1'b0; A[i] = 32'h0;
            WD[i] = 32'h0; funct3[i] = 3'd2;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("d%0d.rstBusy", i), 32'(busy[i]), 32'd0);
            checkOutput($sformatf("d%0d.rstReady", i), 32'(ready[i]), 32'd0);
            checkOutput($sformatf("d%0d.rstRd", i), RD[i], 32'h0);
            checkOutput($sformatf("d%0d.rstFault", i), 32'(fault[i]), 32'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b0; req[i] = 1'b0;
        end

        applyStimulus(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2);
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 3'd2);
        applyStimulus(0, 1'b1, 32'h203, 32'h00000080, 3'd0);
        applyStimulus(0, 1'b0, 32'h203, 32'h0, 3'd0);
        applyStimulus(0, 1'b0, 32'h203, 32'h0, 3'd4);
        applyStimulus(0, 1'b1, 32'h206, 32'h00008001, 3'd1);
        applyStimulus(0, 1'b0, 32'h206, 32'h0, 3'd1);
        applyStimulus(0, 1'b0, 32'h206, 32'h0, 3'd5);
        applyStimulus(0, 1'b0, 32'h200, 32'h0, 3'd2);
        applyStimulus(0, 1'b0, 32'h204, 32'h0, 3'd2);
        applyStimulus(0, 1'b0, 32'h102, 32'h0, 3'd2);
        applyStimulus(0, 1'b1, 32'h101, 32'h55555555, 3'd2);
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 3'd2);
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 3'd3);
        applyStimulus(0, 1'b1, 32'h100, 32'h0, 3'd3);
        applyStimulus(0, 1'b1, 32'h20010, 32'h55AA1234, 3'd2);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 3'd2);
        checkResetAbort(0);

        for (int i = 0; i < NDUT; i++) begin
            checkThroughput(i, 32'h100);
            for (int n = 0; n < 25; n++) begin
                applyStimulus(i, 1'($urandom_range(0, 1)),
                              ($urandom & 32'hFFFE0000) | (32'h400 + 32'($urandom_range(0, 31))),
                              $urandom, 3'($urandom_range(0, 7)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
